// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer.
//   seq_state_t   : sequencer FSM encoding (HOLD, RELEASE, RUN, ASSERT)
//   CAUSE_POR_BIT : rst_cause bit that flags a power-on reset
//   width_min1    : $clog2 clamped to a minimum of one bit
//   max_int       : larger of two ints, for sizing the shared timer
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_ASSERT  = 2'd3
    } seq_state_t;

    localparam int CAUSE_POR_BIT = 0;

    function automatic int width_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_seq_timer.sv
// Loadable down-counter with a terminal-count flag, shared by the hold
// interval and the inter-domain gap interval of the reset sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val on this edge (takes priority over counting)
//   load_val   : interval length minus one
//   tc         : high while the count is zero; the edge that sees tc high
//                is the last edge of the interval
// The count parks at zero rather than wrapping, so an idle timer keeps
// reporting tc until it is reloaded.
module reset_sequencer_seq_timer
    import reset_sequencer_pkg::*;
#(
    parameter int               W       = 4,
    parameter logic [W-1:0]     RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Central reset sequencer. Holds all domains in reset, then releases them
// in order 0..N_DOMAINS-1 with STAGE_GAP cycles between steps; a request in
// RUN asserts them in reverse order, holds, and releases again.
//   clk        : system clock
//   rst_n      : asynchronous active-low power-on reset
//   req        : level-sensitive synchronous reset requests
//   rst_n_out  : per-domain active-low resets, straight from flops
//   busy       : high whenever the sequencer is not in RUN (registered)
//   rst_cause  : sticky cause, bit 0 = power-on, bit k+1 = req[k]
//
// The released domains always form a contiguous block starting at domain 0,
// so a release step is a left shift that inserts a one and an assert step
// is a right shift. The "current index" is therefore implicit in rst_n_out:
// the sequence is done releasing when the vector is all ones and done
// asserting when it reaches zero.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int N_DOMAINS   = 3,
    parameter int N_REQ       = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    output logic [N_DOMAINS-1:0] rst_n_out,
    output logic                 busy,
    output logic [N_REQ:0]       rst_cause
);

    localparam int TMR_W = max_int(width_min1(HOLD_CYCLES), width_min1(STAGE_GAP));
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(STAGE_GAP - 1);
    localparam logic [N_REQ:0]   CAUSE_POR = (N_REQ + 1)'(1) << CAUSE_POR_BIT;
    localparam logic [N_DOMAINS-1:0] DOM_ALL = '1;

    seq_state_t             state_q, state_d;
    logic [N_DOMAINS-1:0]   rst_out_q, rst_out_d;
    logic [N_REQ:0]         cause_q, cause_d;
    logic                   busy_q, busy_d;

    logic                   req_any;
    logic [N_DOMAINS-1:0]   rel_next;
    logic [N_DOMAINS-1:0]   asrt_next;
    logic                   tmr_load;
    logic [TMR_W-1:0]       tmr_val;
    logic                   tmr_tc;

    assign req_any   = |req;
    assign rel_next  = (rst_out_q << 1) | N_DOMAINS'(1);
    assign asrt_next = rst_out_q >> 1;

    // Out of reset the timer already holds the full hold interval, which is
    // the same as "state HOLD, hold counter 0".
    reset_sequencer_seq_timer #(
        .W       (TMR_W),
        .RST_VAL (HOLD_LOAD)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d   = state_q;
        rst_out_d = rst_out_q;
        cause_d   = cause_q;
        tmr_load  = 1'b0;
        tmr_val   = GAP_LOAD;

        case (state_q)
            ST_HOLD: begin
                if (req_any) begin
                    // A request restarts the hold interval; a held request
                    // keeps every domain in reset.
                    cause_d  = cause_q | {req, 1'b0};
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LOAD;
                end else if (tmr_tc) begin
                    rst_out_d = rel_next;
                    tmr_load  = 1'b1;
                    tmr_val   = GAP_LOAD;
                    state_d   = (rel_next == DOM_ALL) ? ST_RUN : ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if (req_any) begin
                    // Abort: the highest released domain falls now and the
                    // assert sequence carries on from there.
                    cause_d   = {req, 1'b0};
                    rst_out_d = asrt_next;
                    tmr_load  = 1'b1;
                    if (asrt_next == '0) begin
                        tmr_val = HOLD_LOAD;
                        state_d = ST_HOLD;
                    end else begin
                        tmr_val = GAP_LOAD;
                        state_d = ST_ASSERT;
                    end
                end else if (tmr_tc) begin
                    rst_out_d = rel_next;
                    tmr_load  = 1'b1;
                    tmr_val   = GAP_LOAD;
                    if (rel_next == DOM_ALL) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (req_any) begin
                    cause_d   = {req, 1'b0};
                    rst_out_d = asrt_next;
                    tmr_load  = 1'b1;
                    // With a single domain the first assert step is also
                    // the last one, so go straight to HOLD.
                    if (asrt_next == '0) begin
                        tmr_val = HOLD_LOAD;
                        state_d = ST_HOLD;
                    end else begin
                        tmr_val = GAP_LOAD;
                        state_d = ST_ASSERT;
                    end
                end
            end

            ST_ASSERT: begin
                // The assert sequence runs to completion; requests only
                // add to the recorded cause.
                cause_d = cause_q | {req, 1'b0};
                if (tmr_tc) begin
                    rst_out_d = asrt_next;
                    tmr_load  = 1'b1;
                    if (asrt_next == '0) begin
                        tmr_val = HOLD_LOAD;
                        state_d = ST_HOLD;
                    end else begin
                        tmr_val = GAP_LOAD;
                    end
                end
            end

            default: begin
                state_d  = ST_HOLD;
                tmr_load = 1'b1;
                tmr_val  = HOLD_LOAD;
            end
        endcase

        busy_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_HOLD;
            rst_out_q <= '0;
            cause_q   <= CAUSE_POR;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            rst_out_q <= rst_out_d;
            cause_q   <= cause_d;
            busy_q    <= busy_d;
        end
    end

    assign rst_n_out = rst_out_q;
    assign busy      = busy_q;
    assign rst_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [2:0] rno;
    logic       busy;
    logic [2:0] cause;

    logic [1:0] req1;
    logic [0:0] rno1;
    logic       busy1;
    logic [2:0] cause1;

    int checks   = 0;
    int failures = 0;

    reset_sequencer #(
        .N_DOMAINS(3), .N_REQ(2), .HOLD_CYCLES(16), .STAGE_GAP(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .rst_n_out(rno), .busy(busy), .rst_cause(cause)
    );

    reset_sequencer #(
        .N_DOMAINS(1), .N_REQ(2), .HOLD_CYCLES(1), .STAGE_GAP(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1),
        .rst_n_out(rno1), .busy(busy1), .rst_cause(cause1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ordering invariant: released domains are contiguous from domain 0.
    always @(negedge clk) begin
        checks++;
        if ((rno & (rno + 3'd1)) !== 3'd0) begin
            failures++;
            $display("FAIL order_invariant rst_n_out=%b not contiguous from bit 0", rno);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse rst_n; on return the next posedge is edge 1 after release.
    task automatic do_reset();
        step();
        #2 rst_n = 1'b0;
        step();
        step();
        #3 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        req1  = 2'b00;
        step();
        step();
        checks++;
        if (rno !== 3'b000 || busy !== 1'b1 || cause !== 3'b001) begin
            failures++;
            $display("FAIL reset_vals got rno=%b busy=%b cause=%b want 000 1 001", rno, busy, cause);
        end
        checks++;
        if (rno1 !== 1'b0 || busy1 !== 1'b1 || cause1 !== 3'b001) begin
            failures++;
            $display("FAIL reset_vals_small got rno=%b busy=%b cause=%b want 0 1 001", rno1, busy1, cause1);
        end
        #3 rst_n = 1'b1;
    endtask

    task automatic test_power_on();
        logic [2:0] exp;
        for (int e = 1; e <= 26; e++) begin
            step();
            exp = (e >= 24) ? 3'b111 : (e >= 20) ? 3'b011 : (e >= 16) ? 3'b001 : 3'b000;
            if (e == 15 || e == 16 || e == 19 || e == 20 || e == 23 || e == 24) begin
                checks++;
                if (rno !== exp) begin
                    failures++;
                    $display("FAIL power_on e=%0d rno=%b want %b", e, rno, exp);
                end
            end
            if (e == 23 || e == 24) begin
                checks++;
                if (busy !== (e == 23)) begin
                    failures++;
                    $display("FAIL power_on_busy e=%0d busy=%b want %b", e, busy, (e == 23));
                end
            end
        end
        checks++;
        if (cause !== 3'b001) begin
            failures++;
            $display("FAIL power_on_cause got %b want 001", cause);
        end
    endtask

    task automatic test_req_pulse();
        logic [2:0] exp;
        req = 2'b01;
        for (int k = 0; k <= 34; k++) begin
            step();
            if (k == 0) req = 2'b00;
            exp = (k >= 32) ? 3'b111 : (k >= 28) ? 3'b011 : (k >= 24) ? 3'b001 :
                  (k >= 8) ? 3'b000 : (k >= 4) ? 3'b001 : 3'b011;
            if (k == 0 || k == 3 || k == 4 || k == 8 || k == 23 || k == 24 || k == 28 || k == 31 || k == 32) begin
                checks++;
                if (rno !== exp) begin
                    failures++;
                    $display("FAIL req_pulse k=%0d rno=%b want %b", k, rno, exp);
                end
            end
            if (k == 0 || k == 31 || k == 32) begin
                checks++;
                if (busy !== (k != 32)) begin
                    failures++;
                    $display("FAIL req_pulse_busy k=%0d busy=%b want %b", k, busy, (k != 32));
                end
            end
        end
        checks++;
        if (cause !== 3'b010) begin
            failures++;
            $display("FAIL req_pulse_cause got %b want 010", cause);
        end
    endtask

    // Request during ASSERT adds to the cause; request during HOLD restarts it.
    task automatic test_assert_hold_merge();
        req = 2'b01;
        for (int k = 0; k <= 34; k++) begin
            step();
            case (k)
                0: req = 2'b00;
                1: req = 2'b10;
                2: req = 2'b00;
                9: req = 2'b01;
                10: req = 2'b00;
                default: ;
            endcase
            if (k == 2) begin
                checks++;
                if (cause !== 3'b110) begin
                    failures++;
                    $display("FAIL merge_assert_cause got %b want 110", cause);
                end
            end
            if (k == 4 || k == 8 || k == 25 || k == 26 || k == 30 || k == 34) begin
                checks++;
                if (rno !== ((k == 4) ? 3'b001 : (k == 26) ? 3'b001 : (k == 30) ? 3'b011 :
                             (k == 34) ? 3'b111 : 3'b000)) begin
                    failures++;
                    $display("FAIL merge_seq k=%0d rno=%b", k, rno);
                end
            end
        end
        checks++;
        if (cause !== 3'b110 || busy !== 1'b0) begin
            failures++;
            $display("FAIL merge_end got cause=%b busy=%b want 110 0", cause, busy);
        end
    endtask

    task automatic test_req_held();
        req = 2'b10;
        for (int k = 0; k <= 99; k++) begin
            step();
            if (k == 0 || k == 8 || k == 50 || k == 99) begin
                checks++;
                if (rno !== ((k == 0) ? 3'b011 : 3'b000)) begin
                    failures++;
                    $display("FAIL held k=%0d rno=%b", k, rno);
                end
            end
        end
        req = 2'b00;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k == 15 || k == 16 || k == 20 || k == 24) begin
                checks++;
                if (rno !== ((k == 15) ? 3'b000 : (k == 16) ? 3'b001 : (k == 20) ? 3'b011 : 3'b111)) begin
                    failures++;
                    $display("FAIL held_release k=%0d rno=%b", k, rno);
                end
            end
        end
        checks++;
        if (cause !== 3'b100 || busy !== 1'b0) begin
            failures++;
            $display("FAIL held_end got cause=%b busy=%b want 100 0", cause, busy);
        end
    endtask

    task automatic test_async_reset();
        req = 2'b01;
        for (int k = 0; k <= 4; k++) begin
            step();
            if (k == 0) req = 2'b00;
        end
        checks++;
        if (rno !== 3'b001 || cause !== 3'b010) begin
            failures++;
            $display("FAIL async_pre got rno=%b cause=%b want 001 010", rno, cause);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rno !== 3'b000 || busy !== 1'b1 || cause !== 3'b001) begin
            failures++;
            $display("FAIL async_now got rno=%b busy=%b cause=%b want 000 1 001", rno, busy, cause);
        end
        #1 rst_n = 1'b1;
        for (int e = 1; e <= 26; e++) begin
            step();
            if (e == 15 || e == 16 || e == 20 || e == 24) begin
                checks++;
                if (rno !== ((e == 15) ? 3'b000 : (e == 16) ? 3'b001 : (e == 20) ? 3'b011 : 3'b111)) begin
                    failures++;
                    $display("FAIL async_restart e=%0d rno=%b", e, rno);
                end
            end
        end
    endtask

    task automatic test_release_abort();
        do_reset();
        for (int e = 1; e <= 50; e++) begin
            step();
            if (e == 20) req = 2'b01;
            if (e == 21) req = 2'b00;
            if (e == 20 || e == 21 || e == 24 || e == 25 || e == 40 || e == 41 || e == 45 || e == 49) begin
                checks++;
                if (rno !== ((e == 20) ? 3'b011 : (e == 21 || e == 24 || e == 41) ? 3'b001 :
                             (e == 45) ? 3'b011 : (e == 49) ? 3'b111 : 3'b000)) begin
                    failures++;
                    $display("FAIL abort e=%0d rno=%b", e, rno);
                end
            end
        end
        checks++;
        if (cause !== 3'b010 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_end got cause=%b busy=%b want 010 0", cause, busy);
        end
    endtask

    task automatic test_small();
        do_reset();
        step();
        checks++;
        if (rno1 !== 1'b1 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL small_poweron got rno=%b busy=%b want 1 0", rno1, busy1);
        end
        req1 = 2'b01;
        step();
        req1 = 2'b00;
        checks++;
        if (rno1 !== 1'b0 || busy1 !== 1'b1 || cause1 !== 3'b010) begin
            failures++;
            $display("FAIL small_req got rno=%b busy=%b cause=%b want 0 1 010", rno1, busy1, cause1);
        end
        step();
        checks++;
        if (rno1 !== 1'b1 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL small_release got rno=%b busy=%b want 1 0", rno1, busy1);
        end
        req1 = 2'b10;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (rno1 !== 1'b0) begin
                failures++;
                $display("FAIL small_held k=%0d rno=%b want 0", k, rno1);
            end
        end
        req1 = 2'b00;
        step();
        checks++;
        if (rno1 !== 1'b1 || cause1 !== 3'b100 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL small_held_end got rno=%b cause=%b busy=%b want 1 100 0", rno1, cause1, busy1);
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_req_pulse();
        test_assert_hold_merge();
        test_req_held();
        test_async_reset();
        test_release_abort();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
